// File: rtl/ntt_pkg.sv
// Moduli table and Barrett constants shared by the modular multiplier datapath.
// Each entry carries its own bit length k; MU = floor(4^k / q) fits in k+1 bits.
package ntt_pkg;

    localparam int unsigned Q_COUNT = 4;
    localparam int unsigned IDX_W   = $clog2(Q_COUNT);

    localparam logic [31:0] Q_TABLE [Q_COUNT] = '{
        32'd12289, 32'd536608769, 32'd998244353, 32'd1073479681
    };

    function automatic int unsigned bit_len(input logic [31:0] x);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (x[i]) n = i + 1;
        end
        return n;
    endfunction

    function automatic logic [32:0] calc_mu(input logic [31:0] q);
        logic [64:0] num;
        logic [64:0] quo;
        num = 65'd1 << (2 * bit_len(q));
        quo = num / {33'd0, q};
        return quo[32:0];
    endfunction

    localparam int unsigned K_TABLE [Q_COUNT] = '{
        bit_len(Q_TABLE[0]), bit_len(Q_TABLE[1]), bit_len(Q_TABLE[2]), bit_len(Q_TABLE[3])
    };

    localparam logic [32:0] MU_TABLE [Q_COUNT] = '{
        calc_mu(Q_TABLE[0]), calc_mu(Q_TABLE[1]), calc_mu(Q_TABLE[2]), calc_mu(Q_TABLE[3])
    };

endpackage

// File: rtl/barrett_reducer.sv
// Three-stage Barrett reduction of a 2W-bit product p modulo Q_TABLE[sel].
// The final register doubles as the pipeline result register, hence its reset.
module barrett_reducer
    import ntt_pkg::*;
#(
    parameter int unsigned W = 30
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [2*W-1:0]   p,
    input  logic [IDX_W-1:0] sel,
    output logic [W-1:0]     r
);

    localparam int unsigned HW = W + 1;
    localparam int unsigned RW = W + 2;
    localparam int unsigned TW = 2 * W + 2;

    logic [HW-1:0]    p_hi;
    logic [HW-1:0]    mu;
    logic [HW-1:0]    q_hat;
    logic [TW-1:0]    t3;
    logic [RW-1:0]    p3;
    logic [RW-1:0]    q_mul;
    logic [RW-1:0]    r4;
    logic [RW-1:0]    q4;
    logic [RW-1:0]    s1;
    logic [W-1:0]     s2;
    logic [IDX_W-1:0] sel3;
    logic [IDX_W-1:0] sel4;

    // Shifts use each modulus' own width k (k = W for full-width moduli) so short test moduli reduce exactly.
    always_comb begin
        p_hi  = HW'(p >> (K_TABLE[sel] - 1));
        mu    = MU_TABLE[sel][HW-1:0];
        q_hat = HW'(t3 >> (K_TABLE[sel3] + 1));
        q_mul = RW'(q_hat) * RW'(Q_TABLE[sel3][W-1:0]);
        q4    = RW'(Q_TABLE[sel4][W-1:0]);
        s1    = (r4 >= q4) ? r4 - q4 : r4;
        s2    = W'((s1 >= q4) ? s1 - q4 : s1);
    end

    always_ff @(posedge clk) begin
        if (en) begin
            t3   <= TW'(p_hi) * TW'(mu);
            p3   <= p[RW-1:0];
            sel3 <= sel;
            r4   <= p3 - q_mul;
            sel4 <= sel3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r <= '0;
        end else if (en) begin
            r <= s2;
        end
    end

endmodule

// File: rtl/modular_mult_pipe.sv
// Five-stage pipelined modular multiplier c = (a*b) mod q[mod_sel] with valid/ready flow control.
// The whole pipe advances together; a stalled output freezes every stage.
module modular_mult_pipe
    import ntt_pkg::*;
#(
    parameter int unsigned W       = 30,
    parameter int unsigned NUM_MOD = 4,
    parameter int unsigned TAG_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [W-1:0]               a,
    input  logic [W-1:0]               b,
    input  logic [$clog2(NUM_MOD)-1:0] mod_sel,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [W-1:0]               c,
    output logic [TAG_W-1:0]           out_tag,
    output logic                       out_err
);

    localparam int unsigned SEL_LIMIT = (NUM_MOD < Q_COUNT) ? NUM_MOD : Q_COUNT;

    logic             advance;
    logic [IDX_W-1:0] in_idx;
    logic [W-1:0]     in_q;
    logic             v1, v2, v3, v4;
    logic [W-1:0]     a1, b1;
    logic [IDX_W-1:0] idx1, idx2;
    logic [TAG_W-1:0] tag1, tag2, tag3, tag4;
    logic             err1, err2, err3, err4;
    logic [2*W-1:0]   p2;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    always_comb begin
        in_idx = '0;
        if (32'(mod_sel) < SEL_LIMIT) in_idx = IDX_W'(mod_sel);
        in_q = Q_TABLE[in_idx][W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            v4        <= 1'b0;
            out_valid <= 1'b0;
            out_tag   <= '0;
            out_err   <= 1'b0;
        end else if (advance) begin
            v1        <= in_valid;
            v2        <= v1;
            v3        <= v2;
            v4        <= v3;
            out_valid <= v4;
            out_tag   <= tag4;
            out_err   <= err4;
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            a1   <= a;
            b1   <= b;
            idx1 <= in_idx;
            tag1 <= in_tag;
            err1 <= (a >= in_q) || (b >= in_q);
            p2   <= (2*W)'(a1) * (2*W)'(b1);
            idx2 <= idx1;
            tag2 <= tag1;
            err2 <= err1;
            tag3 <= tag2;
            err3 <= err2;
            tag4 <= tag3;
            err4 <= err3;
        end
    end

    barrett_reducer #(
        .W(W)
    ) u_reduce (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (advance),
        .p    (p2),
        .sel  (idx2),
        .r    (c)
    );

endmodule

// File: doc/modular_mult_pipe.md
MODULAR_MULT_PIPE -- requirements
Module: modular_mult_pipe

Interface
REQ-001 Parameter W, default 30: operand and result width in bits, legal range 16..32.
REQ-002 Parameter NUM_MOD, default 4: number of moduli selectable at run time.
REQ-003 Parameter TAG_W, default 8: width of the sideband tag carried alongside each operation.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port in_valid, input, 1 bit: an operand pair is offered.
REQ-007 Port in_ready, output, 1 bit: the block accepts the operand pair this cycle.
REQ-008 Port a, input, W bits: multiplicand.
REQ-009 Port b, input, W bits: multiplier.
REQ-010 Port mod_sel, input, $clog2(NUM_MOD) bits: index into the moduli table, sampled with a and b.
REQ-011 Port in_tag, input, TAG_W bits: opaque sideband field.
REQ-012 Port out_valid, output, 1 bit: a result is presented.
REQ-013 Port out_ready, input, 1 bit: the downstream block accepts the result.
REQ-014 Port c, output, W bits: (a*b) mod q[mod_sel].
REQ-015 Port out_tag, output, TAG_W bits: in_tag of the same operation.
REQ-016 Port out_err, output, 1 bit: set when a >= q or b >= q for that operation.

Function
REQ-017 Transfer rule: input transfer when in_valid && in_ready at a clock edge; output transfer when out_valid && out_ready at a clock edge.
REQ-018 Pipeline: five stages, so a result appears exactly 5 cycles after its input transfer when out_ready stays high.
  - S1: register a, b, sel, tag; compute the range check.
  - S2: p = a*b (2W bits).
  - S3: t = (p >> (W-1)) * MU[sel].
  - S4: r = p - (t >> (W+1))*q, taken modulo 2^(W+2).
  - S5: up to two conditional subtractions of q.
REQ-019 Barrett constant: MU[i] = floor(4^W / q[i]), precomputed, W+1 bits.
REQ-020 Correctness: when a < q and b < q, c SHALL equal (a*b) mod q exactly, with 0 <= c < q.
REQ-021 Out-of-range operands: when a >= q or b >= q, out_err SHALL be 1 and c SHALL be the S5 value (not checked for correctness); the tag and ordering are still preserved.
REQ-022 Each stage has a valid bit; an empty bubble advances freely.
REQ-023 Stall rule: advance = !out_valid || out_ready. When advance = 0 all stages hold and in_ready = 0. in_ready = advance, combinational and independent of in_valid.
REQ-024 Ordering and loss: results emerge in input order; none is dropped or duplicated under any out_ready pattern.
REQ-025 Throughput: with out_ready held high, one operation is accepted per cycle with no bubbles.
REQ-026 Outputs are stable while stalled: c, out_tag and out_err do not change while out_valid && !out_ready.
REQ-027 Moduli: each q[i] is odd, with 2^(W-1) < q[i] < 2^W, or a smaller prime for test entries; mod_sel >= NUM_MOD selects entry 0.

Reset
REQ-028 While rst_n = 0, all stage valid bits and out_valid SHALL be 0, and c, out_tag and out_err SHALL be 0.
REQ-029 in_ready SHALL be 1 in reset.
REQ-030 Reset mid-operation discards all in-flight operations.
REQ-031 The first input transfer may occur on the first edge after rst_n deasserts.
REQ-032 Datapath registers other than outputs need no reset.

Structure
REQ-033 Shared package ntt_pkg SHALL hold the moduli table q[], the MU[] table and the function computing MU, indexed by mod_sel.
REQ-034 The S3–S5 reduction SHALL be the sub-module barrett_reducer (inputs p and sel plus a stall enable; output r; 3-cycle latency).
REQ-035 Multipliers are inferred so that DSP mapping is possible; each multiply has a register on both its input and its output.

Verification (W=30, q[0]=12289, q[1]=536608769)
REQ-036 sel=0, a=12288, b=12288, out_ready=1 -> c=1, out_err=0, out_valid exactly 5 cycles after the transfer.
REQ-037 sel=1, back-to-back pairs a=536608768,b=2, then a=0,b=536608768, then a=1,b=1, tags 1,2,3 -> c=536608767, 0, 1 on consecutive cycles with tags 1,2,3.
REQ-038 Back-pressure: 8 consecutive inputs, out_ready low for cycles 6–10 -> in_ready low during the stall, no result lost, order preserved, c held constant while stalled.
REQ-039 sel=0, a=12289, b=5 -> out_err=1 with the tag preserved.
REQ-040 rst_n pulsed low while 3 operations are in flight -> out_valid=0 immediately; after release, no stale results emerge and a new input yields its result 5 cycles later.
REQ-041 Random test: 10^5 random in-range operands with random sel and random out_ready compared against a reference model -> zero mismatches.
